// File: rtl/fir_pkg.sv
// Shared types and helpers for the FIR tap scheduler: FSM state encoding, default widths and
// ring-address arithmetic.
package fir_pkg;

  localparam int unsigned DWIDTH_DEF = 16;
  localparam int unsigned AWIDTH_DEF = 6;

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StRead,
    StDrain
  } state_e;

  // Ring-address subtraction: (a - b) mod 2^aw.
  function automatic int unsigned wrap_sub(input int unsigned a, input int unsigned b,
                                           input int unsigned aw);
    return (a - b) & ((32'd1 << aw) - 32'd1);
  endfunction

endpackage

// File: rtl/fir_tap_sched_if.sv
// Bundle between the ADC sample source, the FIR tap scheduler and the ring RAM + MAC datapath.
// master = scheduler side, slave = source/datapath side.
interface fir_tap_sched_if
  import fir_pkg::*;
#(
  parameter int unsigned DWIDTH = DWIDTH_DEF,
  parameter int unsigned AWIDTH = AWIDTH_DEF
);
  logic              smp_vld;
  logic [DWIDTH-1:0] smp_in;
  logic              smp_rdy;
  logic              ovr_clr;
  logic              mem_we;
  logic [AWIDTH-1:0] mem_waddr;
  logic [DWIDTH-1:0] mem_wdata;
  logic              mem_re;
  logic [AWIDTH-1:0] mem_raddr;
  logic [AWIDTH-1:0] coef_addr;
  logic              mac_clr;
  logic              mac_en;
  logic              mac_last;
  logic              drdy;
  logic              busy;
  logic              ovr;

  modport master (
    input  smp_vld, smp_in, ovr_clr,
    output smp_rdy, mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr, coef_addr,
           mac_clr, mac_en, mac_last, drdy, busy, ovr
  );

  modport slave (
    output smp_vld, smp_in, ovr_clr,
    input  smp_rdy, mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr, coef_addr,
           mac_clr, mac_en, mac_last, drdy, busy, ovr
  );
endinterface

// File: rtl/fir_ring_ptr.sv
// Ring bookkeeping for the FIR delay line: write pointer, saturating fill count and the
// next-cycle read address (newest sample minus tap index, modulo ring depth).
module fir_ring_ptr
  import fir_pkg::*;
#(
  parameter int unsigned AWIDTH = AWIDTH_DEF,
  parameter int unsigned NTAPS  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_step,
  input  logic [AWIDTH-1:0] k_next,
  output logic [AWIDTH-1:0] wptr,
  output logic [AWIDTH:0]   fill,
  output logic [AWIDTH-1:0] raddr_next
);

  localparam logic [AWIDTH:0] FillMax = (AWIDTH + 1)'(NTAPS);

  logic [AWIDTH-1:0] wptr_q, wptr_d, base_q, base_d;
  logic [AWIDTH:0]   fill_q, fill_d;

  always_comb begin
    wptr_d = wptr_q;
    base_d = base_q;
    fill_d = fill_q;
    if (wr_step) begin
      base_d = wptr_q;
      wptr_d = wptr_q + 1'b1;
      fill_d = (fill_q < FillMax) ? fill_q + 1'b1 : fill_q;
    end
  end

  // Uses base_d so the first read address is ready in the same cycle the write completes.
  assign raddr_next = AWIDTH'(wrap_sub(32'(base_d), 32'(k_next), AWIDTH));
  assign wptr       = wptr_q;
  assign fill       = fill_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      base_q <= '0;
      fill_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      base_q <= base_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/fir_tap_sched.sv
// FIR tap scheduler: writes each sample into the ring RAM, walks NTAPS taps backwards and
// strobes the MAC. Define FIR_SCHED_SKID_EN to hold one sample arriving while busy.
module fir_tap_sched
  import fir_pkg::*;
#(
  parameter int unsigned DWIDTH  = DWIDTH_DEF,
  parameter int unsigned AWIDTH  = AWIDTH_DEF,
  parameter int unsigned NTAPS   = 32,
  parameter int unsigned MAC_LAT = 2
) (
  input logic             clk,
  input logic             rst,
  fir_tap_sched_if.master bus
);

  localparam int unsigned     DcntW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [AWIDTH-1:0] KLast = AWIDTH'(NTAPS - 1);
  localparam logic [DcntW-1:0]  DLast = DcntW'(MAC_LAT - 1);

  state_e             state_q, state_d;
  logic [AWIDTH-1:0]  k_q, k_d;
  logic [DcntW-1:0]   dcnt_q, dcnt_d;
  logic               ovr_q, ovr_d, drop;
  logic [DWIDTH-1:0]  wdata_d;
  logic [AWIDTH-1:0]  wptr, raddr_next;
  logic [AWIDTH:0]    fill;
  logic               rd, smp_rdy_d;
`ifdef FIR_SCHED_SKID_EN
  logic               skid_full_q, skid_full_d;
  logic [DWIDTH-1:0]  skid_q, skid_d;
`endif

  logic               mem_we_q, mem_re_q, mac_clr_q, mac_en_q, mac_last_q;
  logic               drdy_q, busy_q, smp_rdy_q;
  logic [AWIDTH-1:0]  mem_waddr_q, mem_raddr_q, coef_addr_q;
  logic [DWIDTH-1:0]  mem_wdata_q;

  fir_ring_ptr #(
    .AWIDTH (AWIDTH),
    .NTAPS  (NTAPS)
  ) u_ring_ptr (
    .clk        (clk),
    .rst        (rst),
    .wr_step    (state_q == StWrite),
    .k_next     (k_d),
    .wptr       (wptr),
    .fill       (fill),
    .raddr_next (raddr_next)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    dcnt_d  = dcnt_q;
    wdata_d = '0;
    drop    = 1'b0;
`ifdef FIR_SCHED_SKID_EN
    skid_full_d = skid_full_q;
    skid_d      = skid_q;
`endif
    unique case (state_q)
      StIdle: begin
`ifdef FIR_SCHED_SKID_EN
        if (skid_full_q) begin
          state_d     = StWrite;
          wdata_d     = skid_q;
          skid_full_d = 1'b0;
        end
`endif
        if (state_d == StIdle && bus.smp_vld) begin
          state_d = StWrite;
          wdata_d = bus.smp_in;
        end
      end
      StWrite: begin
        state_d = StRead;
        k_d     = '0;
      end
      StRead: begin
        if (k_q == KLast) begin
          state_d = StDrain;
          dcnt_d  = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      StDrain: begin
        if (dcnt_q == DLast) state_d = StIdle;
        else                 dcnt_d  = dcnt_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase

`ifdef FIR_SCHED_SKID_EN
    // Samples not taken straight from IDLE park in the skid; IDLE frees the skid the same cycle.
    if (bus.smp_vld && (state_q != StIdle || skid_full_q)) begin
      if (!skid_full_q || state_q == StIdle) begin
        skid_full_d = 1'b1;
        skid_d      = bus.smp_in;
      end else begin
        drop = 1'b1;
      end
    end
    smp_rdy_d = !skid_full_d;
`else
    drop      = bus.smp_vld && (state_q != StIdle);
    smp_rdy_d = (state_d == StIdle);
`endif
    // A drop in the same cycle as a clear wins.
    ovr_d = drop | (ovr_q & ~bus.ovr_clr);
  end

  assign rd = (state_q == StRead);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      k_q         <= '0;
      dcnt_q      <= '0;
      ovr_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      mem_re_q    <= 1'b0;
      mem_raddr_q <= '0;
      coef_addr_q <= '0;
      mac_clr_q   <= 1'b0;
      mac_en_q    <= 1'b0;
      mac_last_q  <= 1'b0;
      drdy_q      <= 1'b0;
      busy_q      <= 1'b0;
      smp_rdy_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      dcnt_q      <= dcnt_d;
      ovr_q       <= ovr_d;
      mem_we_q    <= (state_d == StWrite);
      mem_waddr_q <= (state_d == StWrite) ? wptr : '0;
      mem_wdata_q <= wdata_d;
      mem_re_q    <= (state_d == StRead);
      mem_raddr_q <= (state_d == StRead) ? raddr_next : '0;
      // Tap strobes follow the read slot by one cycle to match the RAM latency.
      coef_addr_q <= rd ? k_q : '0;
      mac_clr_q   <= rd && (k_q == '0);
      mac_en_q    <= rd && ({1'b0, k_q} < fill);
      mac_last_q  <= rd && (k_q == KLast);
      drdy_q      <= (state_q == StDrain) && (state_d == StIdle);
      busy_q      <= (state_d != StIdle);
      smp_rdy_q   <= smp_rdy_d;
    end
  end

`ifdef FIR_SCHED_SKID_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_full_q <= 1'b0;
      skid_q      <= '0;
    end else begin
      skid_full_q <= skid_full_d;
      skid_q      <= skid_d;
    end
  end
`endif

  assign bus.smp_rdy   = smp_rdy_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_waddr = mem_waddr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_re    = mem_re_q;
  assign bus.mem_raddr = mem_raddr_q;
  assign bus.coef_addr = coef_addr_q;
  assign bus.mac_clr   = mac_clr_q;
  assign bus.mac_en    = mac_en_q;
  assign bus.mac_last  = mac_last_q;
  assign bus.drdy      = drdy_q;
  assign bus.busy      = busy_q;
  assign bus.ovr       = ovr_q;

endmodule

// File: tb/tb_fir_tap_sched.sv
// Scoreboard bench for fir_tap_sched: the driver queues expected RAM/MAC/drdy events with their
// cycle numbers, a negedge monitor pops and compares whenever the DUT strobes.
module tb_fir_tap_sched;

  localparam int unsigned NTAPS   = 32;
  localparam int unsigned MAC_LAT = 2;
  localparam int unsigned RING    = 64;

  typedef struct {
    int unsigned cyc;
    int unsigned a;
    int unsigned d;
  } ev_t;

  logic        tb_clk_64 = 1'b0;
  logic        tb_rstn   = 1'b0;
  int unsigned cyc       = 0;
  int unsigned n_checks  = 0;
  int unsigned n_errors  = 0;
  bit          mon_en    = 1'b0;
  ev_t         wr_q[$], rd_q[$], tap_q[$], dr_q[$];
  int unsigned m_wptr = 0, m_fill = 0;
  int unsigned fr_first = 0, fr_last = 0, fr_en = 0;
  bit          got_first = 1'b0, re_prev = 1'b0;

  fir_tap_sched_if #(.DWIDTH(16), .AWIDTH(6)) bus ();

  fir_tap_sched #(
    .DWIDTH  (16),
    .AWIDTH  (6),
    .NTAPS   (NTAPS),
    .MAC_LAT (MAC_LAT)
  ) dut (
    .clk (tb_clk_64),
    .rst (~tb_rstn),
    .bus (bus)
  );

  always #5 tb_clk_64 = ~tb_clk_64;
  always @(posedge tb_clk_64) cyc <= cyc + 1;

  function automatic void check(input string nm, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Expected events for a sample handshaken in cycle c.
  task automatic expect_frame(input int unsigned c, input logic [15:0] d);
    int unsigned base = m_wptr;
    int unsigned fl;
    wr_q.push_back('{c + 1, m_wptr, 32'(d)});
    m_wptr = (m_wptr + 1) % RING;
    if (m_fill < NTAPS) m_fill++;
    for (int unsigned k = 0; k < NTAPS; k++) begin
      fl = ((k == 0) ? 4 : 0) + ((k < m_fill) ? 2 : 0) + ((k == NTAPS - 1) ? 1 : 0);
      rd_q.push_back('{c + 2 + k, (base + RING - k) % RING, 0});
      tap_q.push_back('{c + 3 + k, k, fl});
    end
    dr_q.push_back('{c + NTAPS + 2 + MAC_LAT, 0, 0});
  endtask

  task automatic send(input logic [15:0] d, input bit accepted, output int unsigned c);
    @(posedge tb_clk_64);
    #1;
    bus.smp_vld = 1'b1;
    bus.smp_in  = d;
    c = cyc;
    if (accepted) expect_frame(c, d);
    @(posedge tb_clk_64);
    #1;
    bus.smp_vld = 1'b0;
  endtask

  task automatic frame(input logic [15:0] d, output int unsigned c);
    send(d, 1'b1, c);
    repeat (62) @(posedge tb_clk_64);
  endtask

  always @(negedge tb_clk_64) begin : monitor
    ev_t e;
    if (!mon_en) begin
      re_prev = 1'b0;
    end else begin
      if (bus.mem_we) begin
        check("we_expected", 32'(wr_q.size() > 0), 1);
        if (wr_q.size() > 0) begin
          e = wr_q.pop_front();
          check("we_cycle", cyc, e.cyc);
          check("we_addr", 32'(bus.mem_waddr), e.a);
          check("we_data", 32'(bus.mem_wdata), e.d);
        end
        got_first = 1'b0;
      end
      if (bus.mem_re) begin
        check("re_expected", 32'(rd_q.size() > 0), 1);
        if (rd_q.size() > 0) begin
          e = rd_q.pop_front();
          check("re_cycle", cyc, e.cyc);
          check("re_addr", 32'(bus.mem_raddr), e.a);
        end
        if (!got_first) fr_first = 32'(bus.mem_raddr);
        got_first = 1'b1;
        fr_last   = 32'(bus.mem_raddr);
      end
      if (re_prev || bus.mac_clr || bus.mac_en || bus.mac_last) begin
        check("tap_expected", 32'(tap_q.size() > 0), 1);
        if (tap_q.size() > 0) begin
          e = tap_q.pop_front();
          check("tap_cycle", cyc, e.cyc);
          check("tap_coef", 32'(bus.coef_addr), e.a);
          check("tap_clr_en_last", {29'd0, bus.mac_clr, bus.mac_en, bus.mac_last}, e.d);
        end
        fr_en = bus.mac_clr ? 32'(bus.mac_en) : fr_en + 32'(bus.mac_en);
      end
      if (bus.drdy) begin
        check("drdy_expected", 32'(dr_q.size() > 0), 1);
        if (dr_q.size() > 0) begin
          e = dr_q.pop_front();
          check("drdy_cycle", cyc, e.cyc);
        end
      end
      re_prev = bus.mem_re;
    end
  end

  initial begin : stim
    int unsigned c;
    bus.smp_vld = 1'b0;
    bus.smp_in  = '0;
    bus.ovr_clr = 1'b0;
    repeat (3) @(posedge tb_clk_64);
    #1;
    tb_rstn = 1'b1;
    mon_en  = 1'b1;
    #1;
    check("rst_we", 32'(bus.mem_we), 0);
    check("rst_re", 32'(bus.mem_re), 0);
    check("rst_mac_en", 32'(bus.mac_en), 0);
    check("rst_drdy", 32'(bus.drdy), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_ovr", 32'(bus.ovr), 0);
    check("rst_smp_rdy", 32'(bus.smp_rdy), 1);

    // Samples 1..70 at period 64: fill saturates, write pointer wraps.
    for (int unsigned n = 1; n <= 70; n++) begin
      frame(16'(n), c);
      if (n == 1) begin
        check("s1_en_taps", fr_en, 1);
        check("s1_first_raddr", fr_first, 0);
        check("s1_last_raddr", fr_last, 33);
      end
      if (n == 40) begin
        check("s40_en_taps", fr_en, 32);
        check("s40_first_raddr", fr_first, 39);
        check("s40_last_raddr", fr_last, 8);
        check("s40_ovr", 32'(bus.ovr), 0);
      end
      if (n == 70) begin
        check("s70_first_raddr", fr_first, 5);
        check("s70_last_raddr", fr_last, 38);
        check("s70_en_taps", fr_en, 32);
      end
    end

    // Overrun: extra sample in cycle 10 of a frame, second one with a simultaneous clear.
    send(16'h0047, 1'b1, c);
    repeat (9) @(posedge tb_clk_64);
    #1;
    bus.smp_vld = 1'b1;
    bus.smp_in  = 16'hAAAA;
`ifdef FIR_SCHED_SKID_EN
    expect_frame(c + NTAPS + 2 + MAC_LAT, 16'hAAAA);
`endif
    @(posedge tb_clk_64);
    #1;
    bus.smp_vld = 1'b0;
`ifdef FIR_SCHED_SKID_EN
    check("ovr_after_first", 32'(bus.ovr), 0);
`else
    check("ovr_after_first", 32'(bus.ovr), 1);
`endif
    check("smp_rdy_busy", 32'(bus.smp_rdy), 0);
    check("busy_in_frame", 32'(bus.busy), 1);
    repeat (9) @(posedge tb_clk_64);
    #1;
    bus.smp_vld = 1'b1;
    bus.smp_in  = 16'hBBBB;
    bus.ovr_clr = 1'b1;
    @(posedge tb_clk_64);
    #1;
    bus.smp_vld = 1'b0;
    bus.ovr_clr = 1'b0;
    check("ovr_clr_vs_overrun", 32'(bus.ovr), 1);
    repeat (79) @(posedge tb_clk_64);
    #1;
    bus.ovr_clr = 1'b1;
    @(posedge tb_clk_64);
    #1;
    bus.ovr_clr = 1'b0;
    check("ovr_cleared", 32'(bus.ovr), 0);
    check("idle_busy", 32'(bus.busy), 0);
    check("idle_smp_rdy", 32'(bus.smp_rdy), 1);

    // Reset in the read slot of tap 15.
    send(16'h1234, 1'b1, c);
    repeat (16) @(posedge tb_clk_64);
    #1;
    check("pre_rst_re", 32'(bus.mem_re), 1);
    mon_en = 1'b0;
    #1;
    tb_rstn = 1'b0;
    #1;
    check("mid_rst_re", 32'(bus.mem_re), 0);
    check("mid_rst_raddr", 32'(bus.mem_raddr), 0);
    check("mid_rst_mac_en", 32'(bus.mac_en), 0);
    check("mid_rst_coef", 32'(bus.coef_addr), 0);
    check("mid_rst_busy", 32'(bus.busy), 0);
    check("mid_rst_smp_rdy", 32'(bus.smp_rdy), 1);
    wr_q.delete();
    rd_q.delete();
    tap_q.delete();
    dr_q.delete();
    m_wptr = 0;
    m_fill = 0;
    repeat (2) @(posedge tb_clk_64);
    #1;
    tb_rstn = 1'b1;
    mon_en  = 1'b1;
    frame(16'h5678, c);
    check("post_rst_en_taps", fr_en, 1);
    check("post_rst_first_raddr", fr_first, 0);
    check("post_rst_last_raddr", fr_last, 33);

    for (int i = 0; i < 200 && (wr_q.size() + rd_q.size() + tap_q.size() + dr_q.size()) > 0; i++)
      @(posedge tb_clk_64);
    check("left_we", 32'(wr_q.size()), 0);
    check("left_re", 32'(rd_q.size()), 0);
    check("left_tap", 32'(tap_q.size()), 0);
    check("left_drdy", 32'(dr_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
